// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one ALU among NUM_REQ requesters with round-robin
// arbitration. One operation is in flight at a time: it is granted in IDLE,
// driven onto the ALU for its full latency in EXEC, and returned in RESP.
// Optional statistics counters are built when ALU_SCHED_STATS_EN is defined;
// otherwise stat_ops/stat_errs are tied to zero.
module alu_rr_scheduler #(
  parameter int N       = 8,
  parameter int NUM_REQ = 4,
  parameter int LAT_STD = 2,
  parameter int LAT_MUL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_mode,
  input  logic [4*NUM_REQ-1:0]       req_cmd,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [2*NUM_REQ-1:0]       req_inp_valid,
  input  logic [N*NUM_REQ-1:0]       req_opa,
  input  logic [N*NUM_REQ-1:0]       req_opb,
  output logic                       alu_ce,
  output logic                       alu_mode,
  output logic                       alu_cin,
  output logic [3:0]                 alu_cmd,
  output logic [1:0]                 alu_inp_valid,
  output logic [N-1:0]               alu_opa,
  output logic [N-1:0]               alu_opb,
  input  logic [2*N-1:0]             alu_res,
  input  logic                       alu_err,
  input  logic                       alu_oflow,
  input  logic                       alu_cout,
  input  logic                       alu_g,
  input  logic                       alu_l,
  input  logic                       alu_e,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*N-1:0]             rsp_res,
  output logic [5:0]                 rsp_flags,
  output logic [15:0]                stat_ops,
  output logic [15:0]                stat_errs
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int LMAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
  localparam int CW   = $clog2(LMAX + 1);

  typedef struct packed {
    logic         mode;
    logic [3:0]   cmd;
    logic         cin;
    logic [1:0]   inp_valid;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
  } op_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t               state, state_nx;
  op_t [NUM_REQ-1:0]    req_op;
  op_t                  op;
  op_t                  sel;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_nx;
  logic [IDW-1:0]       gidx;
  logic                 found;
  logic                 sel_illegal;
  logic                 sel_mul;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        op_lat;
  int                   scan;

  // Regroup the flat requester buses into one op_t per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_op[i] = {req_mode[i], req_cmd[4*i +: 4], req_cin[i],
                        req_inp_valid[2*i +: 2], req_opa[N*i +: N], req_opb[N*i +: N]};
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    scan  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[IDW-1:0];
      end
    end
  end

  assign sel         = req_op[gidx];
  assign sel_illegal = (sel.inp_valid == 2'b00);
  assign sel_mul     = sel.mode && (sel.cmd == 4'b1001 || sel.cmd == 4'b1010);
  assign ptr_nx      = (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state plus all handshake and ALU-side outputs; ALU bus is zero outside EXEC.
  always_comb begin
    state_nx      = state;
    req_ready     = '0;
    alu_ce        = 1'b0;
    alu_mode      = 1'b0;
    alu_cin       = 1'b0;
    alu_cmd       = 4'd0;
    alu_inp_valid = 2'b00;
    alu_opa       = '0;
    alu_opb       = '0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready[gidx] = 1'b1;
          state_nx        = sel_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        // Inputs held stable for the whole window; multiply needs this.
        alu_ce        = 1'b1;
        alu_mode      = op.mode;
        alu_cin       = op.cin;
        alu_cmd       = op.cmd;
        alu_inp_valid = op.inp_valid;
        alu_opa       = op.opa;
        alu_opb       = op.opb;
        if (cnt == op_lat) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grant latch, latency counter and single-cycle result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      op        <= '0;
      op_lat    <= '0;
      cnt       <= '0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op     <= sel;
            op_lat <= sel_mul ? CW'(LAT_MUL) : CW'(LAT_STD);
            cnt    <= '0;
            ptr    <= ptr_nx;
            rsp_id <= gidx;
            // Illegal ops never reach the ALU; the response is synthesized here.
            if (sel_illegal) begin
              rsp_res   <= '0;
              rsp_flags <= 6'b100000;
            end
          end
        end
        EXEC: begin
          // Only the sample at cnt==lat is ever forwarded.
          if (cnt == op_lat) begin
            rsp_res   <= alu_res;
            rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  // Saturating counts of completed responses and of error responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_flags[5] && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
    end
  end
`else
  assign stat_ops  = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed plus randomized checks of alu_rr_scheduler
// against a time-window reference model, with a behavioural ALU that only
// presents a true result on the exact capture cycle.
module tb_alu_rr_scheduler;
  localparam int N = 8, NR = 4, LAT_STD = 2, LAT_MUL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]   req_valid = '0, req_ready, req_mode = '0, req_cin = '0;
  logic [4*NR-1:0] req_cmd = '0;
  logic [2*NR-1:0] req_inp_valid = '0;
  logic [N*NR-1:0] req_opa = '0, req_opb = '0;
  logic alu_ce, alu_mode, alu_cin;
  logic [3:0] alu_cmd;
  logic [1:0] alu_inp_valid;
  logic [N-1:0] alu_opa, alu_opb;
  logic [2*N-1:0] alu_res;
  logic alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [1:0] rsp_id;
  logic [15:0] rsp_res;
  logic [5:0] rsp_flags;
  logic [15:0] stat_ops, stat_errs;

  int vectors = 0, miscompares = 0, cyc = 0;

  alu_rr_scheduler #(.N(N), .NUM_REQ(NR), .LAT_STD(LAT_STD), .LAT_MUL(LAT_MUL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
    .req_cin(req_cin), .req_inp_valid(req_inp_valid), .req_opa(req_opa), .req_opb(req_opb),
    .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
    .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_flags(rsp_flags), .stat_ops(stat_ops), .stat_errs(stat_errs));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0] alu_bus;
  assign alu_bus = {alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb};

  // Behavioural ALU: {res, err, oflow, cout, g, l, e}.
  function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c, input logic ci,
                                         input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r, a16, b16;
    logic er, ov, co;
    a16 = {8'd0, a}; b16 = {8'd0, b}; r = '0; er = 1'b0; ov = 1'b0; co = 1'b0;
    if (m) begin
      case (c)
        4'd0:    begin r = a16 + b16; co = r[8]; end
        4'd1:    begin r = {8'd0, a - b}; ov = (a < b); end
        4'd2:    begin r = a16 + b16 + {15'd0, ci}; co = r[8]; end
        4'd9:    r = (a16 + 16'd1) * (b16 + 16'd1);
        4'd10:   r = (a16 << 1) * b16;
        default: er = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:    r = {8'd0, a & b};
        4'd1:    r = {8'd0, a | b};
        4'd6:    r = {8'd0, a ^ b};
        default: er = 1'b1;
      endcase
    end
    if (iv != 2'b11) er = 1'b1;
    return {r, er, ov, co, a > b, a < b, a == b};
  endfunction

  // The ALU shows its true answer only once inputs were held for the op's latency; junk otherwise.
  int ce_run = 0;
  logic [21:0] junk = '0, alu_out;
  always @(posedge clk) begin
    ce_run <= (alu_ce === 1'b1) ? ce_run + 1 : 0;
    junk   <= 22'($urandom);
  end
  always_comb begin
    if (alu_ce === 1'b1 &&
        ce_run == ((alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? LAT_MUL : LAT_STD))
      alu_out = alu_fn(alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb);
    else
      alu_out = junk;
  end
  assign {alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = alu_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s cyc=%0d got=timeout expected=event", nm, cyc);
  endtask

  // Reference model: an op granted at cycle G drives the ALU over G+1..G+1+L
  // and responds from G+2+L (illegal: from G+1) until the handshake.
  bit m_act = 0, m_ill = 0;
  int m_g = 0, m_lat = 0, m_ptr = 0, m_id = 0, m_ops = 0, m_errs = 0, pick;
  logic m_mode, m_cin;
  logic [3:0] m_cmd;
  logic [1:0] m_iv;
  logic [7:0] m_a, m_b;
  logic [21:0] m_out;
  logic [NR-1:0] e_rdy;
  logic [24:0] e_alu;
  bit ex, rs;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 0; m_ptr = 0; m_ops = 0; m_errs = 0;
    end else begin
`ifdef ALU_SCHED_STATS_EN
      chk("stat_ops", stat_ops, 64'(m_ops));
      chk("stat_errs", stat_errs, 64'(m_errs));
`else
      chk("stat_ops", stat_ops, 0);
      chk("stat_errs", stat_errs, 0);
`endif
      if (!m_act) begin
        pick = -1;
        for (int k = 0; k < NR; k++)
          if (pick < 0 && req_valid[(m_ptr + k) % NR]) pick = (m_ptr + k) % NR;
        e_rdy = '0;
        if (pick >= 0) e_rdy[pick] = 1'b1;
        chk("req_ready", req_ready, e_rdy);
        chk("alu_bus_idle", alu_bus, 0);
        chk("rsp_valid_idle", rsp_valid, 0);
        if (pick >= 0) begin
          m_act = 1; m_g = cyc; m_id = pick;
          m_mode = req_mode[pick]; m_cin = req_cin[pick]; m_cmd = req_cmd[4*pick +: 4];
          m_iv = req_inp_valid[2*pick +: 2]; m_a = req_opa[8*pick +: 8]; m_b = req_opb[8*pick +: 8];
          m_ill = (m_iv == 2'b00);
          m_lat = (m_mode && (m_cmd == 4'd9 || m_cmd == 4'd10)) ? LAT_MUL : LAT_STD;
          m_out = m_ill ? {16'h0, 6'b100000} : alu_fn(m_mode, m_cmd, m_cin, m_iv, m_a, m_b);
          m_ptr = (pick + 1) % NR;
        end
      end else begin
        ex = !m_ill && cyc >= m_g + 1 && cyc <= m_g + 1 + m_lat;
        rs = m_ill ? (cyc >= m_g + 1) : (cyc >= m_g + 2 + m_lat);
        e_alu = ex ? {1'b1, m_mode, m_cin, m_cmd, m_iv, m_a, m_b} : '0;
        chk("req_ready_busy", req_ready, 0);
        chk("alu_bus", alu_bus, e_alu);
        chk("rsp_valid", rsp_valid, rs);
        if (rs) begin
          chk("rsp_id", rsp_id, m_id);
          chk("rsp_res", rsp_res, m_out[21:6]);
          chk("rsp_flags", rsp_flags, m_out[5:0]);
          if (rsp_ready) begin
            m_act = 0;
            m_ops++;
            if (m_out[5]) m_errs++;
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic m, input logic [3:0] c, input logic ci,
                         input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
    req_mode[i] = m; req_cmd[4*i +: 4] = c; req_cin[i] = ci;
    req_inp_valid[2*i +: 2] = iv; req_opa[8*i +: 8] = a; req_opb[8*i +: 8] = b;
  endtask

  task automatic new_req(input int i);
    logic m;
    logic [3:0] c;
    logic [1:0] iv;
    case ($urandom_range(0, 7))
      0: begin m = 1; c = 4'd0; end
      1: begin m = 1; c = 4'd1; end
      2: begin m = 1; c = 4'd2; end
      3: begin m = 1; c = 4'd9; end
      4: begin m = 1; c = 4'd10; end
      5: begin m = 0; c = 4'd0; end
      6: begin m = 0; c = 4'd6; end
      default: begin m = 1'($urandom); c = 4'($urandom); end
    endcase
    iv = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    set_req(i, m, c, 1'($urandom), iv, 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated op with literal expectations; called at posedge+1 with the DUT idle.
  task automatic directed(input string nm, input int id, input logic m, input logic [3:0] c,
                          input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input logic [15:0] xres, input logic [5:0] xfl,
                          input int xdly, input int xce, output int g, output int hs);
    int first, ce;
    bit done;
    logic [15:0] rres;
    logic [5:0] rfl;
    logic [1:0] rid;
    set_req(id, m, c, 1'b0, iv, a, b);
    req_valid = '0; req_valid[id] = 1'b1; rsp_ready = (hold == 0);
    g = -1; hs = -1; first = -1; ce = 0; done = 0; rres = '0; rfl = '0; rid = '0;
    for (int k = 0; k < 20 && g < 0; k++) begin
      @(negedge clk);
      if (req_ready[id]) g = cyc;
    end
    if (g < 0) begin
      fail_to({nm, "_grant"});
      return;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      if (first >= 0 && cyc - first >= hold) rsp_ready = 1'b1;
      @(negedge clk);
      if (alu_ce) ce++;
      if (rsp_valid && first < 0) first = cyc;
      if (rsp_valid && rsp_ready) begin
        done = 1; hs = cyc; rres = rsp_res; rfl = rsp_flags; rid = rsp_id;
      end
    end
    if (!done) begin
      fail_to({nm, "_rsp"});
      return;
    end
    chk({nm, "_latency"}, 64'(first - g), 64'(xdly));
    chk({nm, "_ce_cycles"}, 64'(ce), 64'(xce));
    chk({nm, "_hold"}, 64'(hs - first), 64'(hold));
    chk({nm, "_res"}, rres, xres);
    chk({nm, "_flags"}, rfl, xfl);
    chk({nm, "_id"}, rid, 64'(id));
  endtask

  initial begin
    int g, hs, g2, hs2, nrv;
    int order[$];
    int exp_order[4];
    logic [NR-1:0] rdy;
    exp_order = '{0, 2, 0, 2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_bus", alu_bus, 0);
    chk("reset_rsp_res", rsp_res, 0);
    chk("reset_stat_ops", stat_ops, 0);

    @(posedge clk); #1;
    directed("add", 1, 1'b1, 4'd0, 2'b11, 8'd200, 8'd100, 0, 16'h012C, 6'b001100, 4, 3, g, hs);
    @(posedge clk); #1;
    directed("mul", 0, 1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 0, 16'h0014, 6'b000010, 5, 4, g, hs);
    @(posedge clk); #1;
    directed("and", 2, 1'b0, 4'd0, 2'b11, 8'hF0, 8'h3C, 5, 16'h0030, 6'b000100, 4, 3, g, hs);
    @(posedge clk); #1;
    directed("illegal", 3, 1'b1, 4'd0, 2'b00, 8'd5, 8'd6, 0, 16'h0000, 6'b100000, 1, 0, g2, hs2);
    chk("grant_after_hs", 64'(g2), 64'(hs + 1));
    @(negedge clk);
`ifdef ALU_SCHED_STATS_EN
    chk("stats_ops_lit", stat_ops, 4);
    chk("stats_errs_lit", stat_errs, 1);
`else
    chk("stats_ops_lit", stat_ops, 0);
    chk("stats_errs_lit", stat_errs, 0);
`endif

    // Fairness between two always-valid requesters starting from pointer 0.
    do_reset();
    set_req(0, 1'b1, 4'd0, 1'b0, 2'b11, 8'd1, 8'd2);
    set_req(2, 1'b0, 4'd0, 1'b0, 2'b11, 8'd3, 8'd4);
    req_valid = 4'b0101; rsp_ready = 1'b1;
    for (int k = 0; k < 80 && order.size() < 4; k++) begin
      @(negedge clk);
      if (req_ready != 0) order.push_back($clog2(req_ready));
    end
    if (order.size() < 4) fail_to("rr_order");
    else for (int i = 0; i < 4; i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));

    // Reset in the middle of a multiply aborts it without a response.
    do_reset();
    set_req(1, 1'b1, 4'd9, 1'b0, 2'b11, 8'd7, 8'd9);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    g = -1;
    for (int k = 0; k < 20 && g < 0; k++) begin
      @(negedge clk);
      if (req_ready[1]) g = cyc;
    end
    if (g < 0) fail_to("rst_mul_grant");
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_alu_bus", alu_bus, 0);
    chk("rst_abort_rsp_valid", rsp_valid, 0);
    nrv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) nrv++;
    end
    chk("rst_abort_no_rsp", 64'(nrv), 0);

    // Randomized traffic with backpressure and occasional resets.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && rdy[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 99) < 25) begin
          new_req(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 999) < 4);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
